// File: rtl/wb_buffer_bridge_pkg.sv
// rtl/wb_buffer_bridge_pkg.sv - shared codes and FSM states for the Wishbone buffer bridge
package wb_buffer_bridge_pkg;

    localparam logic [1:0] REGION_IM  = 2'b00;
    localparam logic [1:0] REGION_IN  = 2'b01;
    localparam logic [1:0] REGION_WT  = 2'b10;
    localparam logic [1:0] REGION_REG = 2'b11;

    localparam logic [1:0] SUB_CSR = 2'b00;
    localparam logic [1:0] SUB_OB  = 2'b01;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam int         OVF_BIT    = 16;

    localparam logic [1:0] SEL_IM = 2'b00;
    localparam logic [1:0] SEL_IN = 2'b01;
    localparam logic [1:0] SEL_WT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ACK,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_ACK
    } state_e;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_IM,
        TGT_IN,
        TGT_WT,
        TGT_CTRL,
        TGT_STATUS,
        TGT_OB
    } target_e;

endpackage

// File: rtl/wb_buffer_bridge_if.sv
// rtl/wb_buffer_bridge_if.sv - Wishbone classic slave bundle with master/slave views
interface wb_buffer_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational Wishbone address decode into target, index and half
module wb_addr_decode
    import wb_buffer_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic [31:0] adr_i,
    output logic        match_o,
    output logic [1:0]  region_o,
    output target_e     target_o,
    output logic [5:0]  index_o,
    output logic        half_o
);

    always_comb begin
        match_o  = (adr_i[31:12] == BASE_ADDR[31:12]);
        region_o = adr_i[11:10];
        half_o   = adr_i[2];
        index_o  = '0;
        target_o = TGT_NONE;
        if (match_o) begin
            case (region_o)
                REGION_IM: begin
                    target_o = TGT_IM;
                    index_o  = adr_i[7:2];
                end
                REGION_IN: begin
                    target_o = TGT_IN;
                    index_o  = {2'b00, adr_i[5:2]};
                end
                REGION_WT: begin
                    target_o = TGT_WT;
                    index_o  = {2'b00, adr_i[5:2]};
                end
                default: begin
                    // Register page: CSRs need an exact offset, output buffer is 8-byte entries
                    if (adr_i[9:8] == SUB_CSR && adr_i[7:0] == CTRL_OFS) begin
                        target_o = TGT_CTRL;
                    end else if (adr_i[9:8] == SUB_CSR && adr_i[7:0] == STATUS_OFS) begin
                        target_o = TGT_STATUS;
                    end else if (adr_i[9:8] == SUB_OB) begin
                        target_o = TGT_OB;
                        index_o  = {2'b00, adr_i[6:3]};
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_buffer_bridge.sv
// rtl/wb_buffer_bridge.sv - Wishbone slave bridging to IM/input/weight buffers, output buffer and CSRs
module wb_buffer_bridge
    import wb_buffer_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    wb_buffer_bridge_if.slave wb,
    output logic [1:0]        select_buff,
    output logic              buf_wr_en,
    output logic [5:0]        buf_wr_addr,
    output logic [31:0]       buf_wdata,
    output logic              ob_rd_en,
    output logic [3:0]        ob_rd_addr,
    input  logic [63:0]       ob_rdata,
    input  logic              im_empty,
    input  logic              im_full,
    input  logic              in_empty,
    input  logic              in_full,
    input  logic              wt_empty,
    input  logic              wt_full,
    input  logic              ob_empty,
    input  logic              ob_full,
    input  logic              busy,
    input  logic              data_ready,
    output logic              enable_PC_IM,
    output logic              cntrl_reset
);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  select_q, select_d;
    logic        wr_en_q, wr_en_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_en_q, rd_en_d;
    logic [3:0]  rd_addr_q, rd_addr_d;
    logic        half_q, half_d;
    logic        enable_q, enable_d;
    logic        creset_q, creset_d;
    logic        ovf_q, ovf_d;

    logic        dec_match;
    logic [1:0]  dec_region;
    target_e     dec_target;
    logic [5:0]  dec_index;
    logic        dec_half;

    logic        accept;
    logic        is_buf;
    logic        target_full;
    logic        set_ovf;
    logic        clr_ovf;
    logic [31:0] status_word;
    logic [31:0] ctrl_word;

    wb_addr_decode #(.BASE_ADDR(BASE_ADDR)) u_decode (
        .adr_i    (wb.wbs_adr_i),
        .match_o  (dec_match),
        .region_o (dec_region),
        .target_o (dec_target),
        .index_o  (dec_index),
        .half_o   (dec_half)
    );

    assign accept      = (state_q == ST_IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i;
    assign is_buf      = dec_match && (dec_target == TGT_IM || dec_target == TGT_IN ||
                                       dec_target == TGT_WT);
    assign status_word = {15'b0, ovf_q, 6'b0, data_ready, busy, ob_full, ob_empty,
                          wt_full, wt_empty, in_full, in_empty, im_full, im_empty};
    assign ctrl_word   = {30'b0, creset_q, enable_q};

    always_comb begin
        target_full = 1'b0;
        case (dec_target)
            TGT_IM:  target_full = im_full;
            TGT_IN:  target_full = in_full;
            TGT_WT:  target_full = wt_full;
            default: target_full = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        select_d  = select_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wdata_d   = wdata_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        half_d    = half_q;
        enable_d  = enable_q;
        creset_d  = creset_q;
        set_ovf   = 1'b0;
        clr_ovf   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (wb.wbs_we_i && is_buf) begin
                        state_d   = ST_WR_ACK;
                        ack_d     = 1'b1;
                        select_d  = dec_region;
                        wr_addr_d = dec_index;
                        wdata_d   = wb.wbs_dat_i;
                        // Partial-word or full-buffer writes are dropped but still acked
                        if (target_full || wb.wbs_sel_i != 4'hF) begin
                            set_ovf = 1'b1;
                        end else begin
                            wr_en_d = 1'b1;
                        end
                    end else if (!wb.wbs_we_i && dec_target == TGT_OB) begin
                        state_d   = ST_RD_REQ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = dec_index[3:0];
                        half_d    = dec_half;
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (!wb.wbs_we_i) begin
                            case (dec_target)
                                TGT_CTRL:   dat_d = ctrl_word;
                                TGT_STATUS: dat_d = status_word;
                                default:    dat_d = 32'h0;
                            endcase
                        end else if (dec_target == TGT_CTRL && wb.wbs_sel_i[0]) begin
                            enable_d = wb.wbs_dat_i[0];
                            creset_d = wb.wbs_dat_i[1];
                        end else if (dec_target == TGT_STATUS && wb.wbs_sel_i[2] &&
                                     wb.wbs_dat_i[OVF_BIT]) begin
                            clr_ovf = 1'b1;
                        end
                    end
                end
            end
            ST_RD_REQ: begin
                state_d = wb.wbs_cyc_i ? ST_RD_CAP : ST_IDLE;
            end
            ST_RD_CAP: begin
                if (!wb.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = half_q ? ob_rdata[63:32] : ob_rdata[31:0];
                end
            end
            ST_WR_ACK: state_d = ST_IDLE;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A new overflow wins over a clear landing in the same cycle
        ovf_d = set_ovf ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            select_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            half_q    <= 1'b0;
            enable_q  <= 1'b0;
            creset_q  <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            select_q  <= select_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wdata_q   <= wdata_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            half_q    <= half_d;
            enable_q  <= enable_d;
            creset_q  <= creset_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign select_buff  = select_q;
    assign buf_wr_en    = wr_en_q;
    assign buf_wr_addr  = wr_addr_q;
    assign buf_wdata    = wdata_q;
    assign ob_rd_en     = rd_en_q;
    assign ob_rd_addr   = rd_addr_q;
    assign enable_PC_IM = enable_q;
    assign cntrl_reset  = creset_q;

endmodule

// File: doc/wb_buffer_bridge.md
WB_BUFFER_BRIDGE -- requirements
Module: wb_buffer_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base; match when wbs_adr_i[31:12]==BASE_ADDR[31:12].
REQ-002 SHALL have clk input 1, the single rising-edge clock; reset reset_n, synchronous, active-low.
REQ-003 SHALL have wbs_cyc_i, wbs_stb_i, wbs_we_i inputs, 1 bit each, Wishbone classic slave controls.
REQ-004 SHALL have wbs_sel_i input 4; wbs_adr_i input 32; wbs_dat_i input 32.
REQ-005 SHALL have wbs_ack_o output 1; wbs_dat_o output 32.
REQ-006 SHALL have select_buff output 2 (00 IM, 01 input, 10 weight); buf_wr_en output 1; buf_wr_addr output 6; buf_wdata output 32.
REQ-007 SHALL have ob_rd_en output 1; ob_rd_addr output 4; ob_rdata input 64, valid one cycle after ob_rd_en.
REQ-008 SHALL have flag inputs im_empty, im_full, in_empty, in_full, wt_empty, wt_full, ob_empty, ob_full, busy, data_ready, 1 bit each.
REQ-009 SHALL have enable_PC_IM output 1 and cntrl_reset output 1, both driven from the control register.

Function
REQ-010 Address map (byte offsets, region = adr[11:10]): 00 IM word adr[7:2]; 01 input buffer adr[5:2]; 10 weight buffer adr[5:2]; 11 with adr[9:8]=00 holds CTRL 0x000 / STATUS 0x004; 11 with adr[9:8]=01 is the output buffer, entry adr[6:3], adr[2]=1 high half.
REQ-011 FSM states SHALL be IDLE, WR_ACK, RD_REQ, RD_CAP, ACK; a request is accepted only in IDLE with cyc&stb high.
REQ-012 Buffer write accepted at cycle N: at N+1, buf_wr_en=1 for exactly one cycle, with select_buff, buf_wr_addr (zero-extended) and buf_wdata registered from cycle N; wbs_ack_o=1 at N+1.
REQ-013 Buffer write SHALL be suppressed (ack still given) when the target full flag is 1 or wbs_sel_i!=4'hF; either condition sets sticky STATUS[16].
REQ-014 Output-buffer read accepted at N: ob_rd_en=1 and ob_rd_addr valid at N+1; ob_rdata half captured at N+2; wbs_dat_o valid with ack at N+3.
REQ-015 CTRL/STATUS read or write accepted at N SHALL ack at N+1 with wbs_dat_o valid for reads.
REQ-016 CTRL bit0=enable_PC_IM, bit1=cntrl_reset; written when sel[0]=1; other bits read 0.
REQ-017 STATUS read = {15'b0, ovf, 6'b0, data_ready, busy, ob_full, ob_empty, wt_full, wt_empty, in_full, in_empty, im_full, im_empty}; writing 1 to bit16 clears ovf; set has priority over same-cycle clear.
REQ-018 Reads of write-only regions, unmapped offsets, or a non-matching base SHALL ack with data 0; writes there are ignored; no bus hang.
REQ-019 wbs_ack_o SHALL be high at most one cycle per transaction; FSM returns to IDLE the cycle after ack; back-to-back transfers need no idle cycle beyond that.
REQ-020 If wbs_cyc_i drops in RD_REQ or RD_CAP, FSM SHALL return to IDLE without ack.
REQ-021 wbs_dat_o SHALL hold its last value outside ack cycles.

Reset
REQ-022 On reset_n=0 at a clock edge: state IDLE; wbs_ack_o, buf_wr_en, ob_rd_en, enable_PC_IM, ovf = 0; cntrl_reset=1; wbs_dat_o, buf_wr_addr, buf_wdata, ob_rd_addr, select_buff = 0.
REQ-023 Reset mid-transaction SHALL abort with no ack and no strobe in the next cycle.

Structure
REQ-024 Shared package SHALL hold region codes, CTRL/STATUS offsets, select_buff encodings and the FSM state enum.
REQ-025 A single sub-module wb_addr_decode (combinational: match, region, index, half) is natural; everything else is flat.

Verification
REQ-026 Write 0xDEADBEEF to BASE+0x014 with sel=F -> at N+1 buf_wr_en=1, select_buff=00, buf_wr_addr=5, buf_wdata=DEADBEEF, ack=1.
REQ-027 ob_rdata=64'h1111_2222_3333_4444; read BASE+0xD1C -> ob_rd_addr=3; ack at N+3 with dat=0x11112222.
REQ-028 in_full=1, write BASE+0x408 -> ack, no buf_wr_en; STATUS reads bit16=1; write 0x10000 to STATUS -> bit16=0.
REQ-029 After reset, read CTRL -> 0x2; write 0x1 -> enable_PC_IM=1, cntrl_reset=0.
REQ-030 Read 0x4000_0000 -> ack at N+1 with dat 0; read BASE+0x20 (IM, write-only) -> dat 0.
REQ-031 Drop cyc during RD_REQ, or assert reset_n=0 mid-write -> no ack, IDLE, strobes 0 next cycle.
